// File: rtl/mul_dispatcher.sv
// Operand FIFO and issue/collect sequencer for a multi-cycle 32x32 signed multiplier.
// Optional watchdog on the multiplier handshake: define MUL_DISP_TIMEOUT_EN.
module mul_dispatcher #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 96
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   in_multiplier,
  input  logic [31:0]                   in_multiplicand,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [63:0]                   res_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          mul_start,
  output logic                          mul_clear,
  output logic [31:0]                   mul_multiplier,
  output logic [31:0]                   mul_multiplicand,
  input  logic                          mul_done,
  input  logic [63:0]                   mul_result
`ifdef MUL_DISP_TIMEOUT_EN
  ,
  output logic                          timeout_err
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("mul_dispatcher: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CLEAR} state_t;

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [63:0]   mem [FIFO_DEPTH];
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          take;
  logic          capture;

`ifdef MUL_DISP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_cnt;
`endif

  assign full     = (fifo_count == CW'(FIFO_DEPTH));
  assign empty    = (fifo_count == '0);
  // Held low during reset so nothing is accepted while the block is being cleared.
  assign in_ready = reset_n && !full;
  assign push     = in_valid && in_ready && !flush;
  assign pop      = (state == IDLE) && !empty && !flush;
  assign take     = res_valid && res_ready;
  assign capture  = (state == WAIT) && mul_done && (!res_valid || res_ready) && !flush;
  assign busy     = (state != IDLE) || !empty;

  // NOTE: storage arrays carry no reset; only pointers and count define validity,
  // which keeps the array mappable onto plain RAM/register-file cells.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_multiplier, in_multiplicand};
  end

  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= IDLE;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      fifo_count       <= '0;
      res_valid        <= 1'b0;
      res_data         <= '0;
      mul_start        <= 1'b0;
      mul_clear        <= 1'b1;
      mul_multiplier   <= '0;
      mul_multiplicand <= '0;
`ifdef MUL_DISP_TIMEOUT_EN
      tmo_cnt          <= '0;
      timeout_err      <= 1'b0;
`endif
    end else begin
      mul_start <= 1'b0;
      mul_clear <= 1'b0;

      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      fifo_count <= fifo_count + 1'b1;
        else if (pop && !push) fifo_count <= fifo_count - 1'b1;
      end

      // A capture on the same edge as a consume keeps res_valid high with new data.
      if (capture) begin
        res_valid <= 1'b1;
        res_data  <= mul_result;
      end else if (take) begin
        res_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pop) begin
            mul_multiplier   <= mem[rd_ptr][63:32];
            mul_multiplicand <= mem[rd_ptr][31:0];
            mul_start        <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef MUL_DISP_TIMEOUT_EN
          tmo_cnt <= TW'(1);
`endif
          if (flush) begin
            mul_clear <= 1'b1;
            state     <= CLEAR;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (flush || capture) begin
            mul_clear <= 1'b1;
            state     <= CLEAR;
          end
`ifdef MUL_DISP_TIMEOUT_EN
          else if (!mul_done && tmo_cnt == TMO_LAST) begin
            timeout_err <= 1'b1;
            mul_clear   <= 1'b1;
            state       <= CLEAR;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        CLEAR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_dispatcher.sv
// Self-checking bench for mul_dispatcher: behavioural multiplier, queue-based
// reference model checked every cycle, directed scenarios and a random soak.
`timescale 1ns/1ps
module tb_mul_dispatcher;

  localparam int DEPTH = 4;
  localparam int TMO   = 96;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_multiplier = '0;
  logic [31:0]   in_multiplicand = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [63:0]   res_data;
  logic          busy;
  logic [CW-1:0] fifo_count;
  logic          mul_start;
  logic          mul_clear;
  logic [31:0]   mul_multiplier;
  logic [31:0]   mul_multiplicand;
  logic          mul_done = 1'b0;
  logic [63:0]   mul_result = '0;
`ifdef MUL_DISP_TIMEOUT_EN
  logic          timeout_err;
`endif

  always #5 clk = ~clk;

  mul_dispatcher #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_multiplier    (in_multiplier),
    .in_multiplicand  (in_multiplicand),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_data         (res_data),
    .busy             (busy),
    .fifo_count       (fifo_count),
    .mul_start        (mul_start),
    .mul_clear        (mul_clear),
    .mul_multiplier   (mul_multiplier),
    .mul_multiplicand (mul_multiplicand),
    .mul_done         (mul_done),
    .mul_result       (mul_result)
`ifdef MUL_DISP_TIMEOUT_EN
    ,
    .timeout_err      (timeout_err)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // Behavioural multiplier: done appears lat cycles after the start cycle, held until clear.
  int          lat = 4;
  int          mcnt = 0;
  logic        kill_done = 1'b0;
  logic [63:0] mprod = '0;
  always @(posedge clk) begin
    if (mul_clear) begin
      mul_done <= 1'b0;
      mcnt     <= 0;
    end else if (mul_start) begin
      mcnt  <= lat - 1;
      mprod <= prod(mul_multiplier, mul_multiplicand);
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1 && !kill_done) begin
        mul_done   <= 1'b1;
        mul_result <= mprod;
      end
    end
  end

  // Reference model, updated at each falling edge with the events of the last rising edge.
  logic        mon_en = 1'b0;
  int          occ = 0;
  int          max_occ = 0;
  logic [63:0] op_q[$];
  logic [63:0] got_q[$];
  int          start_cyc[$];
  logic        infl_v = 1'b0;
  logic [63:0] infl_val = '0;
  int          infl_age = 0;
  logic        rv_m = 1'b0;
  logic [63:0] rd_m = '0;
  logic        tmo_m = 1'b0;
  logic        p_rst = 1'b1, p_flush = 1'b0, p_push = 1'b0, p_take = 1'b0, p_cap = 1'b0, p_tmo = 1'b0;
  logic [63:0] p_push_val = '0;
  logic        exp_clear;
  int          starts = 0;
  int          cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      exp_clear = 1'b0;
      if (p_rst) begin
        op_q.delete();
        occ = 0; infl_v = 1'b0; rv_m = 1'b0; rd_m = '0; tmo_m = 1'b0;
        exp_clear = 1'b1;
        check("rst_mul_start", mul_start, 0);
        check("rst_operands", {mul_multiplier, mul_multiplicand}, 0);
      end else begin
        if (p_flush) begin
          op_q.delete();
          occ = 0;
          if (infl_v) exp_clear = 1'b1;
          infl_v = 1'b0;
        end else if (p_push) begin
          op_q.push_back(p_push_val);
          occ++;
        end
        if (p_take) rv_m = 1'b0;
        if (p_cap) begin
          rv_m = 1'b1; rd_m = infl_val; infl_v = 1'b0; exp_clear = 1'b1;
        end
        if (p_tmo) begin
          tmo_m = 1'b1; infl_v = 1'b0; exp_clear = 1'b1;
        end
      end
      if (mul_start) begin
        check("start_while_inflight", infl_v, 0);
        check("pop_nonempty", 64'(op_q.size() != 0), 1);
        if (op_q.size() != 0) begin
          check("mul_operands", {mul_multiplier, mul_multiplicand}, op_q[0]);
          void'(op_q.pop_front());
          occ--;
        end
        infl_v = 1'b1;
        infl_val = prod(mul_multiplier, mul_multiplicand);
        infl_age = 0;
        starts++;
        start_cyc.push_back(cyc);
      end else if (infl_v) begin
        infl_age++;
      end
      if (occ > max_occ) max_occ = occ;
      check("fifo_count", fifo_count, occ);
      check("in_ready", in_ready, reset_n && (occ < DEPTH));
      check("res_valid", res_valid, rv_m);
      check("res_data", res_data, rd_m);
      check("mul_clear", mul_clear, exp_clear);
`ifdef MUL_DISP_TIMEOUT_EN
      check("timeout_err", timeout_err, tmo_m);
`endif
      // Decide what the coming rising edge will do.
      p_rst      = !reset_n;
      p_flush    = flush;
      p_push     = in_valid && in_ready && !flush;
      p_push_val = {in_multiplier, in_multiplicand};
      p_take     = rv_m && res_ready;
      if (p_take && reset_n) got_q.push_back(res_data);
      p_cap      = infl_v && mul_done && (!rv_m || res_ready) && !flush;
`ifdef MUL_DISP_TIMEOUT_EN
      p_tmo      = infl_v && !mul_done && !flush && (infl_age == TMO - 1);
`else
      p_tmo      = 1'b0;
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    logic ok;
    int   t;
    ok = 1'b0;
    t  = 0;
    in_valid = 1'b1; in_multiplier = a; in_multiplicand = b;
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = in_ready;
      step();
      t++;
    end
    in_valid = 1'b0;
    check("push_accepted", ok, 1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while ((busy || (res_valid && res_ready)) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("idle_within_budget", 64'(t < 500), 1);
    step();
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int s0, g0;
    reset_n = 1'b0;
    step();
    mon_en = 1'b1;
    step();
    @(negedge clk);
    check("reset_res_valid", res_valid, 0);
    check("reset_res_data", res_data, 0);
    check("reset_mul_clear", mul_clear, 1);
    check("reset_busy", busy, 0);
    check("reset_fifo_count", fifo_count, 0);
    step();
    reset_n = 1'b1;
    step();
    @(negedge clk);
    check("in_ready_after_reset", in_ready, 1);
    step();

    // Single product.
    res_ready = 1'b1; lat = 4; s0 = starts; g0 = got_q.size();
    push(32'd3, 32'd5);
    wait_idle();
    check("t1_starts", starts - s0, 1);
    check("t1_count", got_q.size() - g0, 1);
    if (got_q.size() > g0) check("t1_product", got_q[g0], 64'd15);
    check("t1_busy", busy, 0);

    // Back-to-back pair, in order, at minimum spacing.
    s0 = starts; g0 = got_q.size();
    push(-32'sd2, 32'd7);
    push(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    wait_idle();
    check("t2_starts", starts - s0, 2);
    check("t2_count", got_q.size() - g0, 2);
    if (got_q.size() >= g0 + 2) begin
      check("t2_first", got_q[g0], 64'hFFFF_FFFF_FFFF_FFF2);
      check("t2_second", got_q[g0+1], 64'h3FFF_FFFF_0000_0001);
    end
    if (start_cyc.size() >= 2)
      check("t2_spacing", start_cyc[start_cyc.size()-1] - start_cyc[start_cyc.size()-2], lat + 3);

    // Consumer stalls: first result held, second parked in the multiplier.
    res_ready = 1'b0; s0 = starts; g0 = got_q.size();
    push(32'd11, -32'sd3);
    push(-32'sd100, 32'd100);
    repeat (30) step();
    @(negedge clk);
    check("t3_res_valid", res_valid, 1);
    check("t3_res_held", res_data, -64'sd33);
    check("t3_mul_done_held", mul_done, 1);
    check("t3_busy", busy, 1);
    check("t3_starts", starts - s0, 2);
    step();
    res_ready = 1'b1;
    wait_idle();
    check("t3_count", got_q.size() - g0, 2);
    if (got_q.size() >= g0 + 2) begin
      check("t3_first", got_q[g0], -64'sd33);
      check("t3_second", got_q[g0+1], -64'sd10000);
    end

    // Fill the FIFO while the first operation is in flight.
    lat = 8; max_occ = 0; g0 = got_q.size();
    push(32'd0, 32'hFFFF_FFFF);
    push(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push(32'd123456, -32'sd654321);
    push(32'h8000_0000, 32'h8000_0000);
    push(32'h8000_0000, 32'h7FFF_FFFF);
    @(negedge clk);
    check("t4_full_count", fifo_count, 4);
    check("t4_full_in_ready", in_ready, 0);
    step();
    wait_idle();
    check("t4_max_occ", max_occ, 4);
    check("t4_count", got_q.size() - g0, 5);
    if (got_q.size() >= g0 + 5) begin
      check("t4_p0", got_q[g0],   64'd0);
      check("t4_p1", got_q[g0+1], 64'd1);
      check("t4_p2", got_q[g0+2], prod(32'd123456, -32'sd654321));
      check("t4_p3", got_q[g0+3], 64'h4000_0000_0000_0000);
      check("t4_p4", got_q[g0+4], 64'hC000_0000_8000_0000);
    end

    // Flush during WAIT discards the in-flight product and the queue.
    lat = 20; g0 = got_q.size();
    push(32'd9, 32'd9);
    push(32'd1, 32'd2);
    push(32'd3, 32'd4);
    repeat (5) step();
    flush = 1'b1; in_valid = 1'b1; in_multiplier = 32'd77; in_multiplicand = 32'd77;
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("t5_clear_pulse", mul_clear, 1);
    check("t5_fifo_empty", fifo_count, 0);
    step();
    repeat (30) step();
    @(negedge clk);
    check("t5_no_result", got_q.size() - g0, 0);
    check("t5_res_valid", res_valid, 0);
    step();
    lat = 4;
    push(32'd6, -32'sd4);
    wait_idle();
    check("t5_after_count", got_q.size() - g0, 1);
    if (got_q.size() > g0) check("t5_after", got_q[g0], 64'hFFFF_FFFF_FFFF_FFE8);

    // Reset in the middle of WAIT.
    lat = 20;
    push(32'd5, 32'd5);
    repeat (5) step();
    reset_n = 1'b0;
    step();
    @(negedge clk);
    check("t6_res_data", res_data, 0);
    check("t6_res_valid", res_valid, 0);
    check("t6_mul_clear", mul_clear, 1);
    check("t6_mul_start", mul_start, 0);
    check("t6_busy", busy, 0);
    step();
    reset_n = 1'b1;
    repeat (25) step();

`ifdef MUL_DISP_TIMEOUT_EN
    // Multiplier never answers: watchdog fires TMO cycles after the start.
    begin
      int t;
      lat = 4; kill_done = 1'b1; g0 = got_q.size();
      push(32'd1, 32'd1);
      t = 0;
      @(negedge clk);
      while (!timeout_err && t < 300) begin
        @(negedge clk);
        t++;
      end
      check("t8_tmo_seen", timeout_err, 1);
      if (start_cyc.size() > 0) check("t8_tmo_delay", cyc - start_cyc[start_cyc.size()-1], TMO);
      check("t8_tmo_clear", mul_clear, 1);
      step();
      kill_done = 1'b0;
      push(32'd2, 32'd3);
      wait_idle();
      check("t8_count", got_q.size() - g0, 1);
      if (got_q.size() > g0) check("t8_next", got_q[g0], 64'd6);
    end
`endif

    // Random soak with occasional flushes; every cycle is checked by the model.
    lat = 4;
    for (int i = 0; i < 1500; i++) begin
      lat             = $urandom_range(2, 6);
      in_valid        = ($urandom_range(0, 2) != 0);
      in_multiplier   = pick();
      in_multiplicand = pick();
      res_ready       = ($urandom_range(0, 3) != 0);
      flush           = ($urandom_range(0, 96) == 0);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; res_ready = 1'b1;
    wait_idle();
    check("drain_inflight", infl_v, 0);
    check("drain_queue", op_q.size(), 0);
    check("drain_res_valid", res_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
